// File: rtl/satagtx_pkg.sv
// rtl/satagtx_pkg.sv - shared state encodings, widths and helpers for the SATA clock sequencer
package satagtx_pkg;

    typedef enum logic [2:0] {
        ST_GTXRST   = 3'd0,
        ST_WAIT_PLL = 3'd1,
        ST_DCMRST   = 3'd2,
        ST_WAIT_DCM = 3'd3,
        ST_READY    = 3'd4,
        ST_FAIL     = 3'd5
    } seq_state_e;

    localparam int LOST_CNT_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/satagtx_clk_seq_lane.sv
// rtl/satagtx_clk_seq_lane.sv - per-tile lock synchronisers, bring-up FSM and supervision counters
module satagtx_clk_seq_lane
    import satagtx_pkg::*;
#(
    parameter int C_RST_CYCLES    = 16,
    parameter int C_LOCK_DEBOUNCE = 64,
    parameter int C_LOCK_TIMEOUT  = 65535,
    parameter int C_MAX_RETRY     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic                  plllkdet,
    input  logic                  dcm_locked,
    output logic                  gtx_pllreset,
    output logic                  dcm_reset,
    output logic                  usrclk_ready,
    output logic                  lock_fail,
    output logic [LOST_CNT_W-1:0] lost_cnt,
    output logic [2:0]            seq_state
);

    // One timer serves both the reset-pulse width and the lock timeout.
    localparam int TMR_MAX = (C_LOCK_TIMEOUT > C_RST_CYCLES) ? C_LOCK_TIMEOUT : C_RST_CYCLES;
    localparam int TMR_W   = clog2(TMR_MAX + 1);
    localparam int DEB_W   = clog2(C_LOCK_DEBOUNCE + 1);
    localparam int RTY_W   = clog2(C_MAX_RETRY + 1);

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(C_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(C_LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(TMR_MAX);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(C_LOCK_DEBOUNCE - 1);
    localparam logic [DEB_W-1:0] DEB_SAT  = DEB_W'(C_LOCK_DEBOUNCE);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(C_MAX_RETRY - 1);

    seq_state_e            state_q, state_d;
    logic                  pl_meta_q, pl_meta_d, pl_q, pl_d;
    logic                  dl_meta_q, dl_meta_d, dl_q, dl_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [DEB_W-1:0]      deb_q, deb_d;
    logic [RTY_W-1:0]      retry_q, retry_d;
    logic [LOST_CNT_W-1:0] lost_q, lost_d;
    logic                  gtx_pllreset_q, gtx_pllreset_d;
    logic                  dcm_reset_q, dcm_reset_d;
    logic                  usrclk_ready_q, usrclk_ready_d;
    logic                  lock_fail_q, lock_fail_d;
    logic                  loss_evt, tmo_evt, leave;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_GTXRST;
            pl_meta_q      <= 1'b0;
            pl_q           <= 1'b0;
            dl_meta_q      <= 1'b0;
            dl_q           <= 1'b0;
            tmr_q          <= '0;
            deb_q          <= '0;
            retry_q        <= '0;
            lost_q         <= '0;
            gtx_pllreset_q <= 1'b1;
            dcm_reset_q    <= 1'b1;
            usrclk_ready_q <= 1'b0;
            lock_fail_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pl_meta_q      <= pl_meta_d;
            pl_q           <= pl_d;
            dl_meta_q      <= dl_meta_d;
            dl_q           <= dl_d;
            tmr_q          <= tmr_d;
            deb_q          <= deb_d;
            retry_q        <= retry_d;
            lost_q         <= lost_d;
            gtx_pllreset_q <= gtx_pllreset_d;
            dcm_reset_q    <= dcm_reset_d;
            usrclk_ready_q <= usrclk_ready_d;
            lock_fail_q    <= lock_fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        loss_evt = 1'b0;
        tmo_evt  = 1'b0;
        case (state_q)
            ST_GTXRST: begin
                if (tmr_q == RST_LAST) state_d = ST_WAIT_PLL;
            end
            ST_WAIT_PLL: begin
                if (pl_q && deb_q == DEB_LAST) begin
                    state_d = ST_DCMRST;
                end else if (tmr_q == TMO_LAST) begin
                    tmo_evt = 1'b1;
                    state_d = (retry_q >= RTY_LAST) ? ST_FAIL : ST_GTXRST;
                end
            end
            ST_DCMRST: begin
                if (!pl_q) begin
                    loss_evt = 1'b1;
                    state_d  = ST_GTXRST;
                end else if (tmr_q == RST_LAST) begin
                    state_d = ST_WAIT_DCM;
                end
            end
            ST_WAIT_DCM: begin
                if (!pl_q) begin
                    loss_evt = 1'b1;
                    state_d  = ST_GTXRST;
                end else if (dl_q && deb_q == DEB_LAST) begin
                    state_d = ST_READY;
                end else if (tmr_q == TMO_LAST) begin
                    tmo_evt = 1'b1;
                    state_d = (retry_q >= RTY_LAST) ? ST_FAIL : ST_GTXRST;
                end
            end
            ST_READY: begin
                if (!pl_q) begin
                    loss_evt = 1'b1;
                    state_d  = ST_GTXRST;
                end else if (!dl_q) begin
                    loss_evt = 1'b1;
                    state_d  = ST_DCMRST;
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_GTXRST;
        endcase
        // restart wins over any loss or timeout seen in the same cycle
        if (restart) begin
            state_d  = ST_GTXRST;
            loss_evt = 1'b0;
            tmo_evt  = 1'b0;
        end
    end

    always_comb begin
        pl_meta_d = plllkdet;
        pl_d      = pl_meta_q;
        dl_meta_d = dcm_locked;
        dl_d      = dl_meta_q;
        leave     = restart || (state_d != state_q);

        tmr_d = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + TMR_W'(1);
        deb_d = '0;
        if ((state_q == ST_WAIT_PLL && pl_q) || (state_q == ST_WAIT_DCM && dl_q)) begin
            deb_d = (deb_q == DEB_SAT) ? deb_q : deb_q + DEB_W'(1);
        end
        if (leave) begin
            tmr_d = '0;
            deb_d = '0;
        end

        retry_d = retry_q;
        if (restart || state_d == ST_READY) retry_d = '0;
        else if (tmo_evt)                   retry_d = retry_q + RTY_W'(1);

        lost_d = lost_q;
        if (loss_evt && lost_q != {LOST_CNT_W{1'b1}}) lost_d = lost_q + LOST_CNT_W'(1);

        gtx_pllreset_d = state_d inside {ST_GTXRST, ST_FAIL};
        dcm_reset_d    = state_d inside {ST_GTXRST, ST_WAIT_PLL, ST_DCMRST, ST_FAIL};
        usrclk_ready_d = (state_d == ST_READY);
        lock_fail_d    = (state_d == ST_FAIL);
    end

    assign gtx_pllreset = gtx_pllreset_q;
    assign dcm_reset    = dcm_reset_q;
    assign usrclk_ready = usrclk_ready_q;
    assign lock_fail    = lock_fail_q;
    assign lost_cnt     = lost_q;
    assign seq_state    = state_q;

endmodule

// File: rtl/satagtx_clk_seq.sv
// rtl/satagtx_clk_seq.sv - multi-tile SATA GTX clock bring-up sequencer with combined ready
module satagtx_clk_seq
    import satagtx_pkg::*;
#(
    parameter int C_NUM_TILES     = 1,
    parameter int C_RST_CYCLES    = 16,
    parameter int C_LOCK_DEBOUNCE = 64,
    parameter int C_LOCK_TIMEOUT  = 65535,
    parameter int C_MAX_RETRY     = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_NUM_TILES-1:0]            restart,
    input  logic [C_NUM_TILES-1:0]            tile_plllkdet,
    input  logic [C_NUM_TILES-1:0]            dcm_locked,
    output logic [C_NUM_TILES-1:0]            gtx_pllreset,
    output logic [C_NUM_TILES-1:0]            dcm_reset,
    output logic [C_NUM_TILES-1:0]            usrclk_ready,
    output logic                              all_ready,
    output logic [C_NUM_TILES-1:0]            lock_fail,
    output logic [LOST_CNT_W*C_NUM_TILES-1:0] lost_cnt,
    output logic [3*C_NUM_TILES-1:0]          seq_state
);

    logic all_ready_q, all_ready_d;

    for (genvar i = 0; i < C_NUM_TILES; i++) begin : g_lane
        satagtx_clk_seq_lane #(
            .C_RST_CYCLES    (C_RST_CYCLES),
            .C_LOCK_DEBOUNCE (C_LOCK_DEBOUNCE),
            .C_LOCK_TIMEOUT  (C_LOCK_TIMEOUT),
            .C_MAX_RETRY     (C_MAX_RETRY)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .restart      (restart[i]),
            .plllkdet     (tile_plllkdet[i]),
            .dcm_locked   (dcm_locked[i]),
            .gtx_pllreset (gtx_pllreset[i]),
            .dcm_reset    (dcm_reset[i]),
            .usrclk_ready (usrclk_ready[i]),
            .lock_fail    (lock_fail[i]),
            .lost_cnt     (lost_cnt[LOST_CNT_W*i +: LOST_CNT_W]),
            .seq_state    (seq_state[3*i +: 3])
        );
    end

    always_comb all_ready_d = &usrclk_ready;

    always_ff @(posedge clk) begin
        if (rst) all_ready_q <= 1'b0;
        else     all_ready_q <= all_ready_d;
    end

    assign all_ready = all_ready_q;

endmodule

// File: tb/tb_satagtx_clk_seq.sv
// tb/tb_satagtx_clk_seq.sv - directed self-checking bench for satagtx_clk_seq
module tb_satagtx_clk_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  restart, tile_plllkdet, dcm_locked;
    logic [1:0]  gtx_pllreset, dcm_reset, usrclk_ready, lock_fail;
    logic        all_ready;
    logic [15:0] lost_cnt;
    logic [5:0]  seq_state;
    int          checks = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    satagtx_clk_seq #(
        .C_NUM_TILES(2), .C_RST_CYCLES(4), .C_LOCK_DEBOUNCE(8),
        .C_LOCK_TIMEOUT(100), .C_MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart), .tile_plllkdet(tile_plllkdet),
        .dcm_locked(dcm_locked), .gtx_pllreset(gtx_pllreset), .dcm_reset(dcm_reset),
        .usrclk_ready(usrclk_ready), .all_ready(all_ready), .lock_fail(lock_fail),
        .lost_cnt(lost_cnt), .seq_state(seq_state)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; restart = 2'b00; tile_plllkdet = 2'b11; dcm_locked = 2'b11;
        step(5);
        checks++; if ({gtx_pllreset, dcm_reset} !== 4'b1111) begin fails++; $display("FAIL reset_resets got %b expected 1111", {gtx_pllreset, dcm_reset}); end
        checks++; if ({usrclk_ready, all_ready, lock_fail} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b expected 00000", {usrclk_ready, all_ready, lock_fail}); end
        checks++; if ({lost_cnt, seq_state} !== 22'h0) begin fails++; $display("FAIL reset_cnt_state got %h expected 0", {lost_cnt, seq_state}); end
    endtask

    task automatic test_bringup;
        rst = 1'b0;
        step(3);
        checks++; if (gtx_pllreset !== 2'b11 || seq_state !== 6'o00) begin fails++; $display("FAIL bringup_gtxrst got %b/%o expected 11/00", gtx_pllreset, seq_state); end
        step(1);
        checks++; if (gtx_pllreset !== 2'b00 || seq_state !== 6'o11) begin fails++; $display("FAIL bringup_wait_pll got %b/%o expected 00/11", gtx_pllreset, seq_state); end
        step(11);
        checks++; if (dcm_reset !== 2'b11 || seq_state !== 6'o22) begin fails++; $display("FAIL bringup_dcmrst got %b/%o expected 11/22", dcm_reset, seq_state); end
        step(1);
        checks++; if (dcm_reset !== 2'b00 || seq_state !== 6'o33) begin fails++; $display("FAIL bringup_wait_dcm got %b/%o expected 00/33", dcm_reset, seq_state); end
        step(7);
        checks++; if (usrclk_ready !== 2'b00) begin fails++; $display("FAIL bringup_early_ready got %b expected 00", usrclk_ready); end
        step(1);
        checks++; if (usrclk_ready !== 2'b11 || all_ready !== 1'b0) begin fails++; $display("FAIL bringup_ready got %b/%b expected 11/0", usrclk_ready, all_ready); end
        step(1);
        checks++; if (all_ready !== 1'b1) begin fails++; $display("FAIL bringup_all_ready got %b expected 1", all_ready); end
    endtask

    task automatic test_glitchy_lock;
        int bad = 0;
        for (int c = 0; c <= 104; c++) begin
            restart = (c == 0) ? 2'b01 : 2'b00;
            tile_plllkdet[0] = ((c / 5) % 2) == 1;
            step(1);
            if (c >= 4 && c <= 103 && seq_state[2:0] !== 3'd1) bad++;
            if (c == 104) begin
                checks++; if (seq_state[2:0] !== 3'd0 || gtx_pllreset[0] !== 1'b1) begin fails++; $display("FAIL glitch_timeout got %0d/%b expected 0/1", seq_state[2:0], gtx_pllreset[0]); end
            end
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL glitch_stay_wait_pll got %0d bad cycles expected 0", bad); end
        checks++; if (usrclk_ready[1] !== 1'b1 || all_ready !== 1'b0) begin fails++; $display("FAIL glitch_tile1_indep got %b/%b expected 1/0", usrclk_ready[1], all_ready); end
    endtask

    task automatic test_retry_exhaust;
        tile_plllkdet[0] = 1'b0;
        for (int c = 0; c <= 212; c++) begin
            restart = (c == 0) ? 2'b01 : 2'b00;
            step(1);
            if (c == 104) begin
                checks++; if (seq_state[2:0] !== 3'd0) begin fails++; $display("FAIL retry_first_timeout got %0d expected 0", seq_state[2:0]); end
            end
            if (c == 207) begin
                checks++; if (seq_state[2:0] !== 3'd1 || lock_fail[0] !== 1'b0) begin fails++; $display("FAIL retry_second_wait got %0d/%b expected 1/0", seq_state[2:0], lock_fail[0]); end
            end
            if (c == 208 || c == 212) begin
                checks++; if ({seq_state[2:0], lock_fail[0], gtx_pllreset[0], dcm_reset[0]} !== 6'b101111) begin fails++; $display("FAIL retry_fail_state got %b expected 101111", {seq_state[2:0], lock_fail[0], gtx_pllreset[0], dcm_reset[0]}); end
            end
        end
        restart = 2'b01; tile_plllkdet[0] = 1'b1;
        step(1);
        restart = 2'b00;
        checks++; if (seq_state[2:0] !== 3'd0 || lock_fail[0] !== 1'b0) begin fails++; $display("FAIL recover_restart got %0d/%b expected 0/0", seq_state[2:0], lock_fail[0]); end
        step(24);
        checks++; if (seq_state[2:0] !== 3'd4 || usrclk_ready[0] !== 1'b1) begin fails++; $display("FAIL recover_ready got %0d/%b expected 4/1", seq_state[2:0], usrclk_ready[0]); end
        step(1);
        checks++; if (all_ready !== 1'b1) begin fails++; $display("FAIL recover_all_ready got %b expected 1", all_ready); end
    endtask

    task automatic test_lock_loss;
        dcm_locked[0] = 1'b0; step(1); dcm_locked[0] = 1'b1; step(1);
        checks++; if (seq_state[2:0] !== 3'd4 || usrclk_ready[0] !== 1'b1) begin fails++; $display("FAIL dl_loss_sync_delay got %0d/%b expected 4/1", seq_state[2:0], usrclk_ready[0]); end
        step(1);
        checks++; if ({seq_state[2:0], usrclk_ready[0], all_ready} !== 5'b01001 || lost_cnt[7:0] !== 8'd1) begin fails++; $display("FAIL dl_loss_event got %b/%0d expected 01001/1", {seq_state[2:0], usrclk_ready[0], all_ready}, lost_cnt[7:0]); end
        step(1);
        checks++; if (all_ready !== 1'b0) begin fails++; $display("FAIL dl_loss_all_ready got %b expected 0", all_ready); end
        step(10);
        checks++; if (seq_state[2:0] !== 3'd3) begin fails++; $display("FAIL dl_loss_wait_dcm got %0d expected 3", seq_state[2:0]); end
        step(1);
        checks++; if (seq_state[2:0] !== 3'd4) begin fails++; $display("FAIL dl_loss_return got %0d expected 4", seq_state[2:0]); end
        tile_plllkdet[0] = 1'b0; step(1); tile_plllkdet[0] = 1'b1; step(2);
        checks++; if (seq_state[2:0] !== 3'd0 || lost_cnt[7:0] !== 8'd2 || gtx_pllreset[0] !== 1'b1) begin fails++; $display("FAIL pl_loss_event got %0d/%0d/%b expected 0/2/1", seq_state[2:0], lost_cnt[7:0], gtx_pllreset[0]); end
        step(24);
        checks++; if (seq_state[2:0] !== 3'd4) begin fails++; $display("FAIL pl_loss_return got %0d expected 4", seq_state[2:0]); end
    endtask

    task automatic test_priority;
        tile_plllkdet[0] = 1'b0; step(1); tile_plllkdet[0] = 1'b1; step(1);
        restart = 2'b01; step(1); restart = 2'b00;
        checks++; if (seq_state[2:0] !== 3'd0 || lost_cnt[7:0] !== 8'd2) begin fails++; $display("FAIL restart_priority got %0d/%0d expected 0/2", seq_state[2:0], lost_cnt[7:0]); end
        step(24);
        checks++; if (seq_state[2:0] !== 3'd4) begin fails++; $display("FAIL restart_priority_ready got %0d expected 4", seq_state[2:0]); end
    endtask

    task automatic test_saturation;
        int bad = 0;
        for (int k = 0; k < 300; k++) begin
            dcm_locked[0] = 1'b0; step(1); dcm_locked[0] = 1'b1; step(14);
            if (seq_state[2:0] !== 3'd4) bad++;
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL sat_cycle_ready got %0d bad expected 0", bad); end
        checks++; if (lost_cnt[7:0] !== 8'd255) begin fails++; $display("FAIL sat_lost_cnt got %0d expected 255", lost_cnt[7:0]); end
        checks++; if (lost_cnt[15:8] !== 8'd0) begin fails++; $display("FAIL sat_tile1_lost got %0d expected 0", lost_cnt[15:8]); end
    endtask

    task automatic test_reset_mid;
        restart = 2'b01; step(1); restart = 2'b00; step(18);
        checks++; if (seq_state[2:0] !== 3'd3) begin fails++; $display("FAIL mid_in_wait_dcm got %0d expected 3", seq_state[2:0]); end
        rst = 1'b1; restart = 2'b01; step(1);
        checks++; if ({gtx_pllreset, dcm_reset, usrclk_ready, all_ready, lock_fail} !== 9'b111100000) begin fails++; $display("FAIL mid_reset_flags got %b expected 111100000", {gtx_pllreset, dcm_reset, usrclk_ready, all_ready, lock_fail}); end
        checks++; if ({lost_cnt, seq_state} !== 22'h0) begin fails++; $display("FAIL mid_reset_cnt_state got %h expected 0", {lost_cnt, seq_state}); end
        rst = 1'b0; restart = 2'b00;
    endtask

    initial begin
        test_reset;
        test_bringup;
        test_glitchy_lock;
        test_retry_exhaust;
        test_lock_loss;
        test_priority;
        test_saturation;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
